// File: rtl/gol_engine.sv
// Conway's Game of Life engine: button edge detection, cursor/cell editing,
// generation tick divider and a combinational next-generation datapath.
module gol_engine #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_start,
    input  logic                      btn_reset,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_toggle,
    output logic [ROWS*COLS-1:0]      grid,
    output logic                      paused,
    output logic [15:0]               generation,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      update
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CL = $clog2(COLS);
    localparam int CW = $clog2(TICK_DIV);

    logic [6:0]    btn_now, btn_q, btn_prev, btn_rise;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [N-1:0]  next_grid;
    logic [N-1:0]  toggle_mask;
    logic [3:0]    nbr;

    // Buttons are sampled into btn_q first so no output depends combinationally on them.
    assign btn_now  = {btn_toggle, btn_down, btn_up, btn_right, btn_left, btn_reset, btn_start};
    assign btn_rise = btn_q & ~btn_prev;

    wire rise_start  = btn_rise[0];
    wire rise_reset  = btn_rise[1];
    wire rise_left   = btn_rise[2];
    wire rise_right  = btn_rise[3];
    wire rise_up     = btn_rise[4];
    wire rise_down   = btn_rise[5];
    wire rise_toggle = btn_rise[6];

    assign tick = !paused && (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q    <= '0;
            btn_prev <= '0;
        end else begin
            btn_q    <= btn_now;
            btn_prev <= btn_q;
        end
    end

    // Neighbour count treats everything outside the grid as dead.
    always_comb begin
        next_grid = '0;
        nbr       = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                nbr = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < ROWS) &&
                            (c + dc >= 0) && (c + dc < COLS))
                            nbr = nbr + 4'(grid[(r + dr) * COLS + (c + dc)]);
                    end
                end
                next_grid[r*COLS+c] = grid[r*COLS+c] ? (nbr == 4'd2 || nbr == 4'd3) : (nbr == 4'd3);
            end
        end
    end

    always_comb begin
        toggle_mask = '0;
        toggle_mask[int'(cursor_row) * COLS + int'(cursor_col)] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid       <= '0;
            paused     <= 1'b1;
            generation <= 16'd1;
            cursor_row <= '0;
            cursor_col <= '0;
            update     <= 1'b0;
            tick_cnt   <= '0;
        end else begin
            update <= 1'b0;
            if (rise_reset) begin
                grid       <= '0;
                paused     <= 1'b1;
                generation <= 16'd1;
                cursor_row <= '0;
                cursor_col <= '0;
                update     <= 1'b1;
                tick_cnt   <= '0;
            end else begin
                if (rise_start) begin
                    paused   <= ~paused;
                    tick_cnt <= '0;
                end else if (paused || tick) begin
                    tick_cnt <= '0;
                end else begin
                    tick_cnt <= tick_cnt + CW'(1);
                end

                // tick and editing are mutually exclusive: one needs running, the other paused
                if (tick) begin
                    grid   <= next_grid;
                    update <= 1'b1;
                    if (generation != 16'hFFFF)
                        generation <= generation + 16'd1;
                end

                if (paused) begin
                    if (rise_toggle) begin
                        grid       <= grid ^ toggle_mask;
                        generation <= 16'd1;
                        update     <= 1'b1;
                    end
                    if (rise_down && !rise_up)
                        cursor_row <= (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
                    else if (rise_up && !rise_down)
                        cursor_row <= (cursor_row == '0) ? RW'(ROWS - 1) : cursor_row - RW'(1);
                    if (rise_right && !rise_left)
                        cursor_col <= (cursor_col == CL'(COLS - 1)) ? '0 : cursor_col + CL'(1);
                    else if (rise_left && !rise_right)
                        cursor_col <= (cursor_col == '0) ? CL'(COLS - 1) : cursor_col - CL'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gol_engine.sv
// Self-checking bench for gol_engine (8x8, TICK_DIV=4): every grid write is
// matched against an expected-result queue, plus direct state checks.
module tb_gol_engine;
    localparam logic [6:0] B_START = 7'h01, B_RESET = 7'h02, B_LEFT = 7'h04, B_RIGHT = 7'h08,
                           B_UP = 7'h10, B_DOWN = 7'h20, B_TGL = 7'h40;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        btn_start = 0, btn_reset = 0, btn_left = 0, btn_right = 0;
    logic        btn_up = 0, btn_down = 0, btn_toggle = 0;
    logic [63:0] grid;
    logic        paused, update;
    logic [15:0] generation;
    logic [2:0]  cursor_row, cursor_col;

    gol_engine #(.ROWS(8), .COLS(8), .TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_reset(btn_reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_toggle(btn_toggle), .grid(grid), .paused(paused), .generation(generation),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .update(update)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] g; logic [15:0] gen; } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0;
    int mr = 0, mc = 0;
    logic [63:0] mg = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Each grid write must correspond to the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && update === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_update", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_grid", grid, e.g);
                chk("sb_gen", 64'(generation), 64'(e.gen));
            end
        end
    end

    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                int cnt;
                cnt = 0;
                for (int rr = r - 1; rr <= r + 1; rr++)
                    for (int cc = c - 1; cc <= c + 1; cc++)
                        if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && (rr != r || cc != c))
                            cnt += int'(g[rr*8+cc]);
                n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
            end
        return n;
    endfunction

    task automatic set_btn(input logic [6:0] m);
        {btn_toggle, btn_down, btn_up, btn_right, btn_left, btn_reset, btn_start} = m;
    endtask

    // Called just after a negedge; returns just after the negedge one cycle after the action edge.
    task automatic press(input logic [6:0] m);
        set_btn(m);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        set_btn('0);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic move(input logic [6:0] m);
        press(m);
        if (m == B_UP)    mr = (mr + 7) % 8;
        if (m == B_DOWN)  mr = (mr + 1) % 8;
        if (m == B_LEFT)  mc = (mc + 7) % 8;
        if (m == B_RIGHT) mc = (mc + 1) % 8;
    endtask

    task automatic toggle_cell();
        exp_t e;
        mg[mr*8+mc] = ~mg[mr*8+mc];
        e.g = mg; e.gen = 16'd1;
        exp_q.push_back(e);
        press(B_TGL);
    endtask

    task automatic expect_write(input logic [63:0] g, input logic [15:0] gen);
        exp_t e;
        e.g = g; e.gen = gen;
        exp_q.push_back(e);
    endtask

    task automatic check_state(input string tag, input logic p, input logic [15:0] gen);
        chk({tag, "_grid"}, grid, mg);
        chk({tag, "_paused"}, 64'(paused), 64'(p));
        chk({tag, "_gen"}, 64'(generation), 64'(gen));
        chk({tag, "_row"}, 64'(cursor_row), 64'(mr));
        chk({tag, "_col"}, 64'(cursor_col), 64'(mc));
    endtask

    logic [63:0] blk_h, blk_v, block;

    initial begin
        blk_h = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
        blk_v = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
        block = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);

        // reset defaults
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_state("rst", 1'b1, 16'd1);
        chk("rst_update", 64'(update), 64'd0);
        rst_n = 1'b1;
        cycles(5);
        check_state("idle", 1'b1, 16'd1);

        // edit with wrap, single-shot toggle on a held button
        move(B_UP);
        chk("up_row", 64'(cursor_row), 64'd7);
        move(B_LEFT);
        chk("left_col", 64'(cursor_col), 64'd7);
        toggle_cell();
        check_state("tgl63", 1'b1, 16'd1);
        mg[63] = 1'b0;
        expect_write(mg, 16'd1);
        set_btn(B_TGL);
        repeat (10) @(posedge clk);
        @(negedge clk); set_btn('0);
        cycles(1);
        check_state("hold", 1'b1, 16'd1);

        // lone corner cell dies (no wrap-around neighbours)
        toggle_cell();
        expect_write(life(mg), 16'd2);
        press(B_START);
        cycles(3);
        mg = life(mg);
        chk("corner_dead", grid, 64'd0);
        check_state("corner", 1'b0, 16'd2);
        press(B_START);

        // blinker
        mr = 0; mc = 0; mg = '0;
        expect_write(64'd0, 16'd1);
        press(B_RESET);
        repeat (3) move(B_DOWN);
        repeat (2) move(B_RIGHT);
        toggle_cell(); move(B_RIGHT); toggle_cell(); move(B_RIGHT); toggle_cell();
        chk("blink_set", grid, blk_h);
        expect_write(life(mg), 16'd2);
        press(B_START);
        cycles(2);
        chk("blink_wait_gen", 64'(generation), 64'd1);
        cycles(1);
        chk("blink_g2", grid, blk_v);
        chk("blink_g2_gen", 64'(generation), 64'd2);
        expect_write(life(life(mg)), 16'd3);
        cycles(4);
        chk("blink_g3", grid, blk_h);
        chk("blink_g3_gen", 64'(generation), 64'd3);
        // start edge lands on the same edge as the next tick
        expect_write(blk_v, 16'd4);
        cycles(2);
        press(B_START);
        mg = blk_v;
        check_state("start_on_tick", 1'b1, 16'd4);
        cycles(8);
        check_state("stays_paused", 1'b1, 16'd4);

        // block still life, pause mid-count, edit lockout
        mr = 0; mc = 0; mg = '0;
        expect_write(64'd0, 16'd1);
        press(B_RESET);
        toggle_cell(); move(B_RIGHT); toggle_cell(); move(B_DOWN); toggle_cell();
        move(B_LEFT); toggle_cell();
        chk("block_set", grid, block);
        expect_write(block, 16'd2); expect_write(block, 16'd3); expect_write(block, 16'd4);
        press(B_START);
        cycles(3);
        cycles(8);
        check_state("block_g4", 1'b0, 16'd4);
        cycles(1);
        press(B_START);
        check_state("mid_pause", 1'b1, 16'd4);
        expect_write(block, 16'd5);
        press(B_START);
        cycles(2);
        chk("resume_wait_gen", 64'(generation), 64'd4);
        cycles(1);
        chk("resume_gen", 64'(generation), 64'd5);
        expect_write(block, 16'd6);
        press(B_LEFT | B_UP | B_TGL);
        check_state("lockout", 1'b0, 16'd5);
        press(B_START);
        check_state("lock_pause", 1'b1, 16'd6);

        // reset beats toggle in the same cycle
        expect_write(64'd0, 16'd1);
        press(B_RESET | B_TGL);
        mr = 0; mc = 0; mg = '0;
        check_state("prio", 1'b1, 16'd1);

        // asynchronous reset while running
        toggle_cell(); move(B_RIGHT);
        press(B_START);
        cycles(1);
        #3 rst_n = 1'b0;
        #1;
        mr = 0; mc = 0; mg = '0;
        check_state("async_rst", 1'b1, 16'd1);
        chk("async_rst_upd", 64'(update), 64'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(6);
        check_state("post_rst", 1'b1, 16'd1);

        chk("sb_pending", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/gol_engine.md
# gol_engine

Self-contained Conway's Game of Life engine: a button-driven edit controller, a generation-tick divider and a combinational next-generation datapath around a registered cell grid. It sits between debounced board push-buttons and the display/visualizer logic, which consumes the grid, cursor, generation count and update strobe.

## Interface
Parameters:
- ROWS, default 8: grid rows (≥3).
- COLS, default 8: grid columns (≥3).
- TICK_DIV, default 25_000_000: clk cycles per generation while running (≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  level; rising edge toggles run/pause.
- btn_reset  in  1  level; rising edge clears the game.
- btn_left, btn_right, btn_up, btn_down  in  1 each  level; rising edge moves the cursor.
- btn_toggle  in  1  level; rising edge inverts the cell under the cursor.
- grid  out  ROWS*COLS  cell (r,c) at bit r*COLS+c; 1 = alive.
- paused  out  1  1 = simulation stopped, editing enabled.
- generation  out  16  generation counter; starts at 1.
- cursor_row  out  $clog2(ROWS)  selected row.
- cursor_col  out  $clog2(COLS)  selected column.
- update  out  1  one-cycle strobe, high in the cycle the grid register changes.

## Operation
- Button edge detection: each button is registered; the rising edge is input=1 with the previous sample 0. Holding a button produces exactly one action.
- btn_reset edge has highest priority:
  - grid=0, generation=1, paused=1.
  - cursor=(0,0), tick counter=0, update=1 for one cycle.
  - All other button edges in that cycle are ignored.
- btn_start edge toggles paused. Entering or leaving pause clears the tick counter.
- Editing is accepted only while paused=1; edit edges while running are ignored.
  - Cursor moves wrap: left from col 0 goes to COLS-1; right from COLS-1 goes to 0; up/down wrap on rows the same way.
  - Opposite directions pressed in the same cycle cancel on that axis.
  - btn_toggle inverts grid[cursor_row*COLS+cursor_col] using the pre-move cursor, sets generation=1 and pulses update. Moves in the same cycle still apply.
- Tick generation, while paused=0:
  - The counter increments every cycle.
  - At count TICK_DIV-1 the counter wraps to 0 and a tick fires.
  - While paused=1 the counter is held at 0.
- Datapath: purely combinational next state, one rule for every cell.
  - The neighbour count covers the 8 surrounding cells.
  - Cells outside the grid count as dead (no toroidal wrap).
  - Live cell with 2 or 3 live neighbours stays alive; dead cell with exactly 3 becomes alive; all others die or stay dead.
- On a tick:
  - grid <= next state and update=1.
  - generation increments, saturating at 16'hFFFF.
  - If a start edge arrives in the same cycle, the tick still applies (it is judged on the pre-edge state); paused goes to 1.
- update pulses on every grid write, even when the new grid equals the old one.

## Timing
- Reset values: grid=0, paused=1, generation=1, cursor=(0,0), update=0, tick counter=0, button history=0.
- rst_n is asynchronous, so these values appear immediately on assertion. rst_n deasserted mid-run returns to the same state.
- Button action latency: an input rising before clock edge N is sampled at N; the action is visible in the outputs after edge N+1.
- First evolution after a start edge: exactly TICK_DIV cycles after paused falls. Subsequent evolutions: every TICK_DIV cycles.
- update is registered: high for exactly the cycle following the grid write edge, and never two cycles in a row from a single event.
- All outputs are registered; no combinational path exists from buttons to outputs.

## Test plan
- Reset defaults: hold rst_n=0 mid-run → grid=0, paused=1, generation=1, cursor=(0,0), update=0 immediately. After release, no output changes without button edges.
- Edit with wrap, 8x8 grid:
  - up from (0,0) → cursor (7,0); left → (7,7).
  - btn_toggle → grid bit 63=1, update one cycle, generation=1.
  - Holding btn_toggle high 10 cycles toggles only once.
- Blinker, TICK_DIV=4:
  - Set bits 26,27,28 then start → after 4 cycles grid has bits 19,27,35 only, generation=2.
  - 4 cycles later → bits 26,27,28, generation=3.
- Block and edges:
  - 2x2 block at bits 0,1,8,9 stays unchanged across 3 ticks; update pulses each tick.
  - A lone corner cell at bit 63 dies on the first tick (no wrap).
- Pause and edit lockout:
  - Pausing mid-count resets the counter; resuming waits a full TICK_DIV.
  - Direction and toggle edges while running change neither cursor nor grid.
- Priority: btn_reset and btn_toggle edges in the same cycle → grid=0, cursor (0,0), paused=1. Start edge in the same cycle as a tick → grid evolves once, then paused=1.
